// File: rtl/rti_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rti_write_arbiter
//  Purpose  : Merges NUM_SRC fire-and-forget RTI producer streams into one
//             RTI_Core FIFO write port. Each source has a one-entry holding
//             register. A round-robin arbiter drains the holding registers
//             under fifo_full backpressure. Drops are flagged per source and
//             counted with saturation.
//  Options  : RTI_ARB_SRC_TAG_EN - when defined, the top SRC_ID_WIDTH bits
//             of fifo_din carry the granted source index.
//  Revision : 1.0 - initial release
// ============================================================================
module rti_write_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int SRC_ID_WIDTH = 2
) (
  input  logic                          rtio_clk,
  input  logic                          rtio_resetn,
  input  logic                          flush,
  input  logic                          clear_err,
  input  logic [NUM_SRC-1:0]            src_write,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic                          fifo_full,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [NUM_SRC-1:0]            src_pending,
  output logic [NUM_SRC-1:0]            src_overflow,
  output logic [15:0]                   drop_count
);

  localparam logic [SRC_ID_WIDTH-1:0] C_RR_RESET = SRC_ID_WIDTH'(NUM_SRC - 1);

  logic [NUM_SRC-1:0]     hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0]  hold_data_q [NUM_SRC];
  logic [DATA_WIDTH-1:0]  hold_data_d [NUM_SRC];
  logic [SRC_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                   fifo_write_q, fifo_write_d;
  logic [DATA_WIDTH-1:0]  fifo_din_q, fifo_din_d;
  logic [NUM_SRC-1:0]     overflow_q, overflow_d;
  logic [15:0]            drop_count_q, drop_count_d;

  logic                    w_grant_valid;
  logic [SRC_ID_WIDTH-1:0] w_grant_idx;
  logic [NUM_SRC-1:0]      w_grant_onehot;
  logic [DATA_WIDTH-1:0]   w_payload;
  logic [NUM_SRC-1:0]      w_drops;
  logic [4:0]              w_ndrops;
  logic [16:0]             w_drop_sum;

  // Round-robin search: first valid holding register after rr_ptr, wrapping.
  always_comb begin : p_grant
    logic [SRC_ID_WIDTH:0] cand;
    w_grant_valid  = 1'b0;
    w_grant_idx    = '0;
    w_grant_onehot = '0;
    cand           = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_ID_WIDTH+1)'(k);
      if (cand >= (SRC_ID_WIDTH+1)'(NUM_SRC)) cand = cand - (SRC_ID_WIDTH+1)'(NUM_SRC);
      if (!w_grant_valid && !fifo_full && !flush && hold_valid_q[cand[SRC_ID_WIDTH-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = cand[SRC_ID_WIDTH-1:0];
      end
    end
    if (w_grant_valid) w_grant_onehot[w_grant_idx] = 1'b1;
  end

  // Word presented to the FIFO, optionally tagged with its origin.
  always_comb begin
    w_payload = hold_data_q[w_grant_idx];
`ifdef RTI_ARB_SRC_TAG_EN
    w_payload = {w_grant_idx, hold_data_q[w_grant_idx][DATA_WIDTH-SRC_ID_WIDTH-1:0]};
`endif
  end

  // Next state: grant/drain, per-source load or drop, flush and error tracking.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    rr_ptr_d     = rr_ptr_q;
    fifo_write_d = 1'b0;
    fifo_din_d   = fifo_din_q;
    w_drops      = '0;
    w_ndrops     = '0;
    if (flush) begin
      // Writes arriving during a flush are discarded silently.
      hold_valid_d = '0;
    end else begin
      if (w_grant_valid) begin
        fifo_write_d              = 1'b1;
        fifo_din_d                = w_payload;
        rr_ptr_d                  = w_grant_idx;
        hold_valid_d[w_grant_idx] = 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_write[i]) begin
          // A granted slot may be refilled in the same cycle without loss.
          if (!hold_valid_q[i] || w_grant_onehot[i]) begin
            hold_valid_d[i] = 1'b1;
            hold_data_d[i]  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            w_drops[i] = 1'b1;
            w_ndrops   = w_ndrops + 5'd1;
          end
        end
      end
    end
    w_drop_sum = {1'b0, drop_count_q} + 17'(w_ndrops);
    // A drop coinciding with clear_err survives the clear.
    if (clear_err) begin
      overflow_d   = w_drops;
      drop_count_d = 16'(w_ndrops);
    end else begin
      overflow_d   = overflow_q | w_drops;
      drop_count_d = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge rtio_clk or negedge rtio_resetn) begin
    if (!rtio_resetn) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) hold_data_q[i] <= '0;
      rr_ptr_q     <= C_RR_RESET;
      fifo_write_q <= 1'b0;
      fifo_din_q   <= '0;
      overflow_q   <= '0;
      drop_count_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      rr_ptr_q     <= rr_ptr_d;
      fifo_write_q <= fifo_write_d;
      fifo_din_q   <= fifo_din_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign fifo_write   = fifo_write_q;
  assign fifo_din     = fifo_din_q;
  assign src_pending  = hold_valid_q;
  assign src_overflow = overflow_q;
  assign drop_count   = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rti_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rti_write_arbiter
//  Purpose  : Directed self-checking bench for rti_write_arbiter (4 sources,
//             128-bit words). Expected values are hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rti_write_arbiter;

  logic         clk;
  logic         rtio_resetn;
  logic         flush;
  logic         clear_err;
  logic [3:0]   src_write;
  logic [511:0] src_data;
  logic         fifo_full;
  logic         fifo_write;
  logic [127:0] fifo_din;
  logic [3:0]   src_pending;
  logic [3:0]   src_overflow;
  logic [15:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  rti_write_arbiter #(.NUM_SRC(4), .DATA_WIDTH(128), .SRC_ID_WIDTH(2)) u_dut (
    .rtio_clk     (clk),
    .rtio_resetn  (rtio_resetn),
    .flush        (flush),
    .clear_err    (clear_err),
    .src_write    (src_write),
    .src_data     (src_data),
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_din     (fifo_din),
    .src_pending  (src_pending),
    .src_overflow (src_overflow),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int src, input logic [127:0] d);
    src_data[src*128 +: 128] = d;
  endtask

  // Expected FIFO word for a payload coming from source src.
  function automatic logic [127:0] exp_word(input logic [1:0] src, input logic [127:0] d);
    logic [127:0] w;
    w = d;
`ifdef RTI_ARB_SRC_TAG_EN
    w[127:126] = src;
`else
    if (src == 2'd0) w = d;
`endif
    return w;
  endfunction

  initial begin
    rtio_resetn = 1'b0;
    flush       = 1'b0;
    clear_err   = 1'b0;
    src_write   = '0;
    src_data    = '0;
    fifo_full   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_fifo_write", fifo_write, 0);
    check_eq("rst_fifo_din", fifo_din, 0);
    check_eq("rst_pending", src_pending, 0);
    check_eq("rst_overflow", src_overflow, 0);
    check_eq("rst_drop_count", drop_count, 0);
    rtio_resetn = 1'b1;

    // Single source, minimum latency.
    src_write = 4'b0100;
    set_data(2, 128'hA5);
    tick();
    check_eq("t1_pending_e0", src_pending, 4'b0100);
    check_eq("t1_write_e0", fifo_write, 0);
    src_write = '0;
    tick();
    check_eq("t1_write_e1", fifo_write, 1);
    check_eq("t1_din_e1", fifo_din, exp_word(2'd2, 128'hA5));
    check_eq("t1_pending_e1", src_pending, 0);
    tick();
    check_eq("t1_write_e2", fifo_write, 0);
    check_eq("t1_din_hold", fifo_din, exp_word(2'd2, 128'hA5));

    // All four sources at once after a fresh reset: grants 0,1,2,3.
    rtio_resetn = 1'b0;
    tick();
    rtio_resetn = 1'b1;
    src_write = 4'b1111;
    for (int s = 0; s < 4; s++) set_data(s, 128'h10 + 128'(s));
    tick();
    check_eq("t2_pending", src_pending, 4'b1111);
    src_write = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("t2_write_%0d", k), fifo_write, 1);
      check_eq($sformatf("t2_din_%0d", k), fifo_din, exp_word(2'(k), 128'h10 + 128'(k)));
    end
    check_eq("t2_pending_end", src_pending, 0);
    check_eq("t2_drops", drop_count, 0);
    check_eq("t2_overflow", src_overflow, 0);
    tick();
    check_eq("t2_idle", fifo_write, 0);

    // Backpressure: second write to a full holding register is dropped.
    fifo_full = 1'b1;
    src_write = 4'b0010;
    set_data(1, 128'h21);
    tick();
    check_eq("t3_pending", src_pending, 4'b0010);
    check_eq("t3_full_nowrite", fifo_write, 0);
    set_data(1, 128'h22);
    tick();
    check_eq("t3_overflow", src_overflow, 4'b0010);
    check_eq("t3_drop_count", drop_count, 1);
    src_write = '0;
    fifo_full = 1'b0;
    tick();
    check_eq("t3_write", fifo_write, 1);
    check_eq("t3_din_first", fifo_din, exp_word(2'd1, 128'h21));
    tick();
    check_eq("t3_single_write", fifo_write, 0);

    // Source 0 streams while 1..3 are pending; rr_ptr is 1 here.
    fifo_full = 1'b1;
    clear_err = 1'b1;
    src_write = 4'b1111;
    set_data(0, 128'h40);
    set_data(1, 128'h31);
    set_data(2, 128'h32);
    set_data(3, 128'h33);
    tick();
    check_eq("t4_pending", src_pending, 4'b1111);
    check_eq("t4_cleared", drop_count, 0);
    clear_err = 1'b0;
    fifo_full = 1'b0;
    src_write = 4'b0001;
    set_data(0, 128'h51);
    tick();
    check_eq("t4_din_a1", fifo_din, exp_word(2'd2, 128'h32));
    check_eq("t4_drops_a1", drop_count, 1);
    set_data(0, 128'h52);
    tick();
    check_eq("t4_din_a2", fifo_din, exp_word(2'd3, 128'h33));
    set_data(0, 128'h53);
    tick();
    check_eq("t4_din_a3", fifo_din, exp_word(2'd0, 128'h40));
    check_eq("t4_drops_a3", drop_count, 2);
    set_data(0, 128'h54);
    tick();
    check_eq("t4_din_a4", fifo_din, exp_word(2'd1, 128'h31));
    src_write = '0;
    tick();
    check_eq("t4_din_a5", fifo_din, exp_word(2'd0, 128'h53));
    tick();
    check_eq("t4_idle", fifo_write, 0);
    check_eq("t4_drops", drop_count, 3);
    check_eq("t4_overflow", src_overflow, 4'b0001);

    // Flush with three words pending; a write in the flush cycle is ignored.
    fifo_full = 1'b1;
    src_write = 4'b0111;
    set_data(0, 128'h60);
    set_data(1, 128'h61);
    set_data(2, 128'h62);
    tick();
    check_eq("t5_pending", src_pending, 4'b0111);
    flush     = 1'b1;
    fifo_full = 1'b0;
    src_write = 4'b1000;
    set_data(3, 128'h63);
    tick();
    check_eq("t5_flush_pending", src_pending, 0);
    check_eq("t5_flush_nowrite", fifo_write, 0);
    check_eq("t5_flush_keeps_err", drop_count, 3);
    flush     = 1'b0;
    src_write = '0;
    tick();
    check_eq("t5_after_nowrite", fifo_write, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_eq("t5_clr_overflow", src_overflow, 0);
    check_eq("t5_clr_drops", drop_count, 0);

    // clear_err coinciding with a drop: the new drop survives.
    fifo_full = 1'b1;
    src_write = 4'b0100;
    set_data(2, 128'h80);
    tick();
    set_data(2, 128'h81);
    tick();
    check_eq("t5b_overflow", src_overflow, 4'b0100);
    src_write = 4'b1000;
    set_data(3, 128'h82);
    tick();
    check_eq("t5b_pending", src_pending, 4'b1100);
    set_data(3, 128'h83);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    src_write = '0;
    check_eq("t5b_clr_drop_ovf", src_overflow, 4'b1000);
    check_eq("t5b_clr_drop_cnt", drop_count, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("t5b_flushed", src_pending, 0);

    // Asynchronous reset in the middle of a burst.
    src_write = 4'b1111;
    for (int s = 0; s < 4; s++) set_data(s, 128'h70 + 128'(s));
    tick();
    src_write = 4'b0001;
    tick();
    src_write = '0;
    fifo_full = 1'b0;
    tick();
    check_eq("t6_burst_write", fifo_write, 1);
    rtio_resetn = 1'b0;
    #1;
    check_eq("t6_rst_write", fifo_write, 0);
    check_eq("t6_rst_din", fifo_din, 0);
    check_eq("t6_rst_pending", src_pending, 0);
    check_eq("t6_rst_overflow", src_overflow, 0);
    check_eq("t6_rst_drops", drop_count, 0);
    tick();
    rtio_resetn = 1'b1;
    tick();
    check_eq("t6_post_idle", fifo_write, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
